// File: rtl/idu_is_cp0_queue_if.sv
// Dispatch, wakeup and issue signals of the CP0 issue queue.
// slave is the queue side, master is the dispatch/execute side.
interface idu_is_cp0_queue_if #(
    parameter int DEPTH    = 4,
    parameter int NUM_SRC  = 2,
    parameter int NUM_WAKE = 10,
    parameter int PREG_W   = 6,
    parameter int IID_W    = 5,
    parameter int OPC_W    = 7,
    parameter int IMM_W    = 64
);
    logic                        create_vld;
    logic                        create_rdy;
    logic [IID_W-1:0]            create_iid;
    logic [OPC_W-1:0]            create_opcode;
    logic [NUM_SRC-1:0]          create_src_vld;
    logic [NUM_SRC-1:0]          create_src_ready;
    logic [NUM_SRC*PREG_W-1:0]   create_psrc;
    logic                        create_imm_vld;
    logic [IMM_W-1:0]            create_imm;
    logic [NUM_WAKE-1:0]         wake_vld;
    logic [NUM_WAKE*PREG_W-1:0]  wake_preg;
    logic                        issue_vld;
    logic                        issue_ack;
    logic [IID_W-1:0]            issue_iid;
    logic [OPC_W-1:0]            issue_opcode;
    logic [NUM_SRC-1:0]          issue_src_vld;
    logic [NUM_SRC*PREG_W-1:0]   issue_psrc;
    logic                        issue_imm_vld;
    logic [IMM_W-1:0]            issue_imm;
    logic [$clog2(DEPTH+1)-1:0]  count;

    modport slave (
        input  create_vld, create_iid, create_opcode, create_src_vld, create_src_ready,
               create_psrc, create_imm_vld, create_imm, wake_vld, wake_preg, issue_ack,
        output create_rdy, issue_vld, issue_iid, issue_opcode, issue_src_vld, issue_psrc,
               issue_imm_vld, issue_imm, count
    );

    modport master (
        output create_vld, create_iid, create_opcode, create_src_vld, create_src_ready,
               create_psrc, create_imm_vld, create_imm, wake_vld, wake_preg, issue_ack,
        input  create_rdy, issue_vld, issue_iid, issue_opcode, issue_src_vld, issue_psrc,
               issue_imm_vld, issue_imm, count
    );
endinterface

// File: rtl/idu_is_cp0_queue.sv
// In-order CP0 issue queue: circular buffer with per-source wakeup tracking,
// only the head entry is offered to the CP0 pipe.
module idu_is_cp0_queue #(
    parameter int DEPTH    = 4,
    parameter int NUM_SRC  = 2,
    parameter int NUM_WAKE = 10,
    parameter int PREG_W   = 6,
    parameter int IID_W    = 5,
    parameter int OPC_W    = 7,
    parameter int IMM_W    = 64
) (
    input  logic                  clk,
    input  logic                  rst_clk,
    input  logic                  rtu_global_flush,
    idu_is_cp0_queue_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]           ent_vld;
    logic [IID_W-1:0]           ent_iid     [DEPTH];
    logic [OPC_W-1:0]           ent_opcode  [DEPTH];
    logic [NUM_SRC-1:0]         ent_src_vld [DEPTH];
    logic [NUM_SRC-1:0]         ent_src_rdy [DEPTH];
    logic [NUM_SRC*PREG_W-1:0]  ent_psrc    [DEPTH];
    logic [DEPTH-1:0]           ent_imm_vld;
    logic [IMM_W-1:0]           ent_imm     [DEPTH];

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_SRC-1:0] ent_hit [DEPTH];
    logic [NUM_SRC-1:0] create_hit;
    logic               push;
    logic               pop;

    // Wake-port match per stored source and per incoming source (dispatch bypass).
    always_comb begin
        create_hit = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            ent_hit[e] = '0;
        end
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned w = 0; w < NUM_WAKE; w++) begin
                if (bus.wake_vld[w] &&
                    bus.wake_preg[w*PREG_W +: PREG_W] == bus.create_psrc[i*PREG_W +: PREG_W]) begin
                    create_hit[i] = 1'b1;
                end
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    if (bus.wake_vld[w] &&
                        bus.wake_preg[w*PREG_W +: PREG_W] == ent_psrc[e][i*PREG_W +: PREG_W]) begin
                        ent_hit[e][i] = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.create_rdy    = (cnt != CNT_W'(DEPTH));
    assign bus.issue_vld     = ent_vld[head] & (&(~ent_src_vld[head] | ent_src_rdy[head]));
    assign bus.issue_iid     = ent_iid[head];
    assign bus.issue_opcode  = ent_opcode[head];
    assign bus.issue_src_vld = ent_src_vld[head];
    assign bus.issue_psrc    = ent_psrc[head];
    assign bus.issue_imm_vld = ent_imm_vld[head];
    assign bus.issue_imm     = ent_imm[head];
    assign bus.count         = cnt;

    assign push = bus.create_vld & bus.create_rdy;
    assign pop  = bus.issue_vld & bus.issue_ack;

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            ent_vld     <= '0;
            ent_imm_vld <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                ent_iid[e]     <= '0;
                ent_opcode[e]  <= '0;
                ent_src_vld[e] <= '0;
                ent_src_rdy[e] <= '0;
                ent_psrc[e]    <= '0;
                ent_imm[e]     <= '0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (rtu_global_flush) begin
            ent_vld     <= '0;
            ent_imm_vld <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                ent_iid[e]     <= '0;
                ent_opcode[e]  <= '0;
                ent_src_vld[e] <= '0;
                ent_src_rdy[e] <= '0;
                ent_psrc[e]    <= '0;
                ent_imm[e]     <= '0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (ent_vld[e]) begin
                    ent_src_rdy[e] <= ent_src_rdy[e] | ent_hit[e];
                end
            end
            // Pop clear comes after the wakeup OR so it wins for the head slot;
            // push never targets the head slot while it is being popped.
            if (pop) begin
                ent_vld[head]     <= 1'b0;
                ent_iid[head]     <= '0;
                ent_opcode[head]  <= '0;
                ent_src_vld[head] <= '0;
                ent_src_rdy[head] <= '0;
                ent_psrc[head]    <= '0;
                ent_imm_vld[head] <= 1'b0;
                ent_imm[head]     <= '0;
                head              <= head + PTR_W'(1);
            end
            if (push) begin
                ent_vld[tail]     <= 1'b1;
                ent_iid[tail]     <= bus.create_iid;
                ent_opcode[tail]  <= bus.create_opcode;
                ent_src_vld[tail] <= bus.create_src_vld;
                ent_src_rdy[tail] <= bus.create_src_ready | create_hit;
                ent_psrc[tail]    <= bus.create_psrc;
                ent_imm_vld[tail] <= bus.create_imm_vld;
                ent_imm[tail]     <= bus.create_imm;
                tail              <= tail + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
